// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampled by the system clock, with received/frame_err strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    localparam int HALF_BIT = CLKS_PER_BIT / 2
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_dat,
    output logic       received,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      rx_dat_q;
    logic            received_q;
    logic            frame_err_q;
    logic            rxs;

    assign rxs       = sync_q[1];
    assign rx_dat    = rx_dat_q;
    assign received  = received_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q     <= WAIT_IDLE;
            sync_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_dat_q    <= '0;
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], uart_rxd};
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                WAIT_IDLE: if (rxs) state_q <= IDLE;
                IDLE: if (!rxs) begin
                    state_q <= START;
                    cnt_q   <= '0;
                end
                START: if (cnt_q == HALF_M1) begin
                    // A line that is high again at mid start bit was only a glitch
                    state_q <= rxs ? IDLE : DATA;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end else cnt_q <= cnt_q + 1'b1;
                DATA: if (cnt_q == BIT_M1) begin
                    shift_q <= {rxs, shift_q[7:1]};
                    cnt_q   <= '0;
                    idx_q   <= idx_q + 3'd1;
                    if (idx_q == 3'd7) state_q <= STOP;
                end else cnt_q <= cnt_q + 1'b1;
                STOP: if (cnt_q == BIT_M1) begin
                    cnt_q <= '0;
                    if (rxs) begin
                        rx_dat_q   <= shift_q;
                        received_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_IDLE;
                    end
                end else cnt_q <= cnt_q + 1'b1;
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It oversamples the serial RX pin with the system clock and delivers each received byte as `rx_dat` plus a one-cycle `received` strobe.
- It sits directly upstream of the UART-to-Wishbone command decoder and feeds that block's `rx_dat`/`received` inputs.
- The downstream consumer has no ready/backpressure, so this block never stalls. Each byte is presented exactly once.

Parameters:
- CLKS_PER_BIT, 104, system clocks per UART bit (12 MHz / 115200). Legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), clocks from start-edge detection to the start-bit sample point. Derived; do not override.

Ports:
- i_wb_clk  input  1  system clock, rising edge.
- i_wb_rst_n  input  1  asynchronous, active-low reset.
- uart_rxd  input  1  raw serial line, idle high, asynchronous to i_wb_clk.
- rx_dat  output  8  last correctly framed byte; LSB received first.
- received  output  1  one-cycle strobe; rx_dat is valid from the same cycle.
- frame_err  output  1  one-cycle strobe when the stop bit is sampled low.
- busy  output  1  high while in START/DATA/STOP.

Behaviour:
- Reset (asynchronous, i_wb_rst_n=0):
  - rx_dat=0x00, received=0, frame_err=0, busy=0.
  - Both synchronizer flops=0, state=WAIT_IDLE, bit counter=0, clock counter=0.
- Synchronizer: 2-flop chain on uart_rxd; `rxs` is the second flop. All decisions use rxs only.
- State machine:
  - WAIT_IDLE: stay until rxs=1, then go to IDLE. This prevents a mid-frame reset release or line break from being taken as a start bit.
  - IDLE: when rxs=0, go to START and clear the clock counter.
  - START: count clocks. At counter==HALF_BIT-1, sample rxs:
    - 1 = false start (glitch): go to IDLE, no strobe.
    - 0: go to DATA, clear the counter, bit index=0.
  - DATA: at counter==CLKS_PER_BIT-1, sample rxs into the shift register (LSB first, shift right, new bit into [7]), clear the counter, increment the bit index. After the 8th sample, go to STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rxs:
    - 1: rx_dat<=shift register, received=1 for the next cycle, go to IDLE.
    - 0: frame_err=1 for the next cycle, rx_dat unchanged, go to WAIT_IDLE.
- Latency: received rises exactly 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks after the first clock edge at which uart_rxd is low, ±1 for synchronizer phase.
- Back-to-back frames: IDLE is entered mid-stop-bit, so a start edge arriving immediately after a one-bit stop is caught. Tolerates ≥ ±4% baud mismatch at CLKS_PER_BIT ≥ 8.
- rx_dat holds its value between frames.
- received and frame_err are never high in the same cycle, and never high for more than one cycle.
- Counters: clock counter width = clog2(CLKS_PER_BIT); bit index 3 bits. No wrap inside a frame.
- busy is combinational from state (START/DATA/STOP), so it is registered-state driven.

Test Plan (CLKS_PER_BIT=8 unless noted):
- Ideal frame 0x70 ('p'), then 0x2E ('.') back-to-back with exactly one stop bit → received pulses twice, each one cycle wide; rx_dat=0x70 then 0x2E; frame_err never asserted; pulse spacing 80 clocks.
- Frame 0xA5 at +4% and −4% bit period (CLKS_PER_BIT=26, line driven at 25/27 clocks per bit) → rx_dat=0xA5, received=1 once in each case.
- Low glitch of 3 clocks on idle line → busy rises, then returns to 0 at the start sample; no received, no frame_err, rx_dat unchanged.
- Frame 0x77 with stop bit low, line held low 20 bit times, then high, then frame 0x72 → one frame_err pulse; rx_dat keeps its prior value; no start detected during the low period; then received with rx_dat=0x72.
- Assert i_wb_rst_n=0 during data bit 3 of a frame, release while the line is still low mid-frame → all outputs 0; no received/frame_err for the remainder of that frame; the next complete frame 0x41 is received correctly.
- Reset released with line idle high, frame 0xFF then 0x00 → rx_dat=0xFF then 0x00 (all-ones/all-zeros data with correct stop handling).
